// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between an instruction-fetch read port
// and a byte-strobed data port; partial-strobe writes run as read-modify-write.
module sram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8  // derived from DATA_WIDTH; leave at default
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     i_req_valid,
    output logic                     i_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
    output logic                     i_resp_valid,
    output logic [DATA_WIDTH-1:0]    i_resp_data,

    input  logic                     d_req_valid,
    output logic                     d_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] d_req_addr,
    input  logic                     d_req_write,
    input  logic [DATA_WIDTH-1:0]    d_req_wdata,
    input  logic [STRB_WIDTH-1:0]    d_req_strb,
    output logic                     d_resp_valid,
    output logic [DATA_WIDTH-1:0]    d_resp_data,

    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0]    sram_data,
    output logic                     sram_write_not_read,
    output logic                     sram_enable,
    input  logic [DATA_WIDTH-1:0]    sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_ACK
    } state_t;

    typedef enum logic {
        G_I,
        G_D
    } grant_t;

    state_t                   state_q, state_d;
    grant_t                   owner_q, owner_d;
    grant_t                   last_q,  last_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]    strb_q,  strb_d;

    logic                     grant_i;
    logic                     grant_d;
    logic [DATA_WIDTH-1:0]    merged;

    // Byte merge for the write half of a read-modify-write.
    always_comb begin
        merged = sram_rdata;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // Tie goes to the requester not granted last; reset leaves last=I so D wins first.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == S_IDLE && rst) begin
            if (d_req_valid && (!i_req_valid || last_q == G_I)) begin
                grant_d = 1'b1;
            end else if (i_req_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    // NOTE: every output and next-state signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        last_d              = last_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        strb_d              = strb_q;

        i_req_ready         = 1'b0;
        d_req_ready         = 1'b0;
        i_resp_valid        = 1'b0;
        i_resp_data         = '0;
        d_resp_valid        = 1'b0;
        d_resp_data         = '0;
        sram_address        = '0;
        sram_data           = '0;
        sram_write_not_read = 1'b1;
        sram_enable         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_i) begin
                    i_req_ready         = 1'b1;
                    owner_d             = G_I;
                    last_d              = G_I;
                    addr_d              = i_req_addr;
                    sram_address        = i_req_addr;
                    sram_write_not_read = 1'b0;
                    state_d             = S_RD;
                end else if (grant_d) begin
                    d_req_ready = 1'b1;
                    owner_d     = G_D;
                    last_d      = G_D;
                    addr_d      = d_req_addr;
                    wdata_d     = d_req_wdata;
                    strb_d      = d_req_strb;
                    if (!d_req_write) begin
                        sram_address        = d_req_addr;
                        sram_write_not_read = 1'b0;
                        state_d             = S_RD;
                    end else if (&d_req_strb) begin
                        sram_address = d_req_addr;
                        sram_data    = d_req_wdata;
                        sram_enable  = 1'b1;
                        state_d      = S_WR;
                    end else if (d_req_strb == '0) begin
                        // Nothing to write: acknowledge without touching the SRAM.
                        state_d = S_WR;
                    end else begin
                        sram_address        = d_req_addr;
                        sram_write_not_read = 1'b0;
                        state_d             = S_RMW_RD;
                    end
                end
            end

            S_RD: begin
                if (owner_q == G_I) begin
                    i_resp_valid = 1'b1;
                    i_resp_data  = sram_rdata;
                end else begin
                    d_resp_valid = 1'b1;
                    d_resp_data  = sram_rdata;
                end
                state_d = S_IDLE;
            end

            S_WR: begin
                d_resp_valid = 1'b1;
                state_d      = S_IDLE;
            end

            S_RMW_RD: begin
                sram_address = addr_q;
                sram_data    = merged;
                sram_enable  = 1'b1;
                state_d      = S_RMW_ACK;
            end

            S_RMW_ACK: begin
                d_resp_valid = 1'b1;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= G_I;
            last_q  <= G_I;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    a_no_write_during_read_issue: assert property (
        @(posedge clk) disable iff (!rst) !(sram_enable && !sram_write_not_read));

    a_ready_only_in_idle: assert property (
        @(posedge clk) disable iff (!rst)
        (i_req_ready || d_req_ready) |-> (state_q == S_IDLE));

    a_single_grant: assert property (
        @(posedge clk) disable iff (!rst) !(i_req_ready && d_req_ready));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM
// (registered read, write on enable) and a backdoor preload path.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [9:0]  i_req_addr;
    logic [31:0] i_resp_data;
    logic        d_req_valid, d_req_ready, d_req_write, d_resp_valid;
    logic [9:0]  d_req_addr;
    logic [31:0] d_req_wdata, d_resp_data;
    logic [3:0]  d_req_strb;
    logic [9:0]  sram_address;
    logic [31:0] sram_data, sram_rdata;
    logic        sram_write_not_read, sram_enable;

    logic [31:0] mem [1024];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          cyc = 0;

    int          n_tests = 0;
    int          n_fail = 0;

    logic        acc_en, acc_wnr;
    logic [9:0]  acc_addr;
    logic [31:0] acc_data;
    int          acc_cyc;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_req_valid         (i_req_valid),
        .i_req_ready         (i_req_ready),
        .i_req_addr          (i_req_addr),
        .i_resp_valid        (i_resp_valid),
        .i_resp_data         (i_resp_data),
        .d_req_valid         (d_req_valid),
        .d_req_ready         (d_req_ready),
        .d_req_addr          (d_req_addr),
        .d_req_write         (d_req_write),
        .d_req_wdata         (d_req_wdata),
        .d_req_strb          (d_req_strb),
        .d_resp_valid        (d_resp_valid),
        .d_resp_data         (d_resp_data),
        .sram_address        (sram_address),
        .sram_data           (sram_data),
        .sram_write_not_read (sram_write_not_read),
        .sram_enable         (sram_enable),
        .sram_rdata          (sram_rdata)
    );

    // SRAM model: write when enabled, else capture a read when write_not_read is low.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (sram_enable) begin
            mem[sram_address] <= sram_data;
        end else if (!sram_write_not_read) begin
            sram_rdata <= mem[sram_address];
        end
        if (sram_enable) wr_cnt <= wr_cnt + 1;
        if (!sram_write_not_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] addr, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_addr = addr;
        bd_data = data;
        @(posedge clk);
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge one cycle after the accept edge.
    task automatic do_req(input logic is_d, input logic wr, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb);
        int n;
        if (is_d) begin
            d_req_valid = 1'b1;
            d_req_write = wr;
            d_req_addr  = addr;
            d_req_wdata = wd;
            d_req_strb  = strb;
        end else begin
            i_req_valid = 1'b1;
            i_req_addr  = addr;
        end
        n = 0;
        #1;
        while (!(is_d ? d_req_ready : i_req_ready) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_ready", is_d ? d_req_ready : i_req_ready, 1'b1);
        acc_en   = sram_enable;
        acc_wnr  = sram_write_not_read;
        acc_addr = sram_address;
        acc_data = sram_data;
        acc_cyc  = cyc;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, t_prev;
        logic exp_d;

        rst = 1'b0;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = '0;
        d_req_wdata = '0;   d_req_strb = '0;

        // 1) reset values
        #12;
        check("rst_i_ready", i_req_ready, 1'b0);
        check("rst_d_ready", d_req_ready, 1'b0);
        check("rst_i_resp_valid", i_resp_valid, 1'b0);
        check("rst_d_resp_valid", d_resp_valid, 1'b0);
        check("rst_i_resp_data", i_resp_data, 32'h0);
        check("rst_d_resp_data", d_resp_data, 32'h0);
        check("rst_enable", sram_enable, 1'b0);
        check("rst_wnr", sram_write_not_read, 1'b1);
        check("rst_addr", sram_address, 10'h0);
        check("rst_data", sram_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_wr_cnt", wr_cnt, 0);
        check("idle_rd_cnt", rd_cnt, 0);
        check("idle_d_ready", d_req_ready, 1'b0);

        // 2) full write, then fetch read of the same word
        do_req(1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        check("fw_acc_en", acc_en, 1'b1);
        check("fw_acc_addr", acc_addr, 10'd5);
        check("fw_acc_data", acc_data, 32'hDEADBEEF);
        check("fw_d_resp_valid", d_resp_valid, 1'b1);
        check("fw_d_resp_data", d_resp_data, 32'h0);
        check("fw_ready_busy", d_req_ready, 1'b0);
        @(negedge clk);
        check("fw_resp_pulse", d_resp_valid, 1'b0);
        check("fw_mem5", mem[5], 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 10'd5, 32'h0, 4'h0);
        check("fr_acc_wnr", acc_wnr, 1'b0);
        check("fr_i_resp_valid", i_resp_valid, 1'b1);
        check("fr_i_resp_data", i_resp_data, 32'hDEADBEEF);
        check("fr_d_resp_idle", d_resp_valid, 1'b0);
        check("fr_d_data_zero", d_resp_data, 32'h0);
        @(negedge clk);
        check("fr_resp_pulse", i_resp_valid, 1'b0);

        // 3) partial-strobe write as read-modify-write
        preload(10'd7, 32'h11223344);
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1'b1, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0101);
        check("rmw_acc_enable", acc_en, 1'b0);
        check("rmw_acc_wnr", acc_wnr, 1'b0);
        check("rmw_no_early_ack", d_resp_valid, 1'b0);
        check("rmw_wr_enable", sram_enable, 1'b1);
        check("rmw_wr_addr", sram_address, 10'd7);
        check("rmw_wr_data", sram_data, 32'h11BB33DD);
        @(negedge clk);
        check("rmw_ack", d_resp_valid, 1'b1);
        check("rmw_ack_data", d_resp_data, 32'h0);
        check("rmw_rd_count", rd_cnt - r0, 1);
        check("rmw_wr_count", wr_cnt - w0, 1);
        check("rmw_mem7", mem[7], 32'h11BB33DD);
        @(negedge clk);
        do_req(1'b1, 1'b0, 10'd7, 32'h0, 4'h0);
        check("rmw_readback", d_resp_data, 32'h11BB33DD);
        check("rmw_rb_valid", d_resp_valid, 1'b1);
        @(negedge clk);

        // 4) both requesters continuously valid: grants alternate starting with D
        do_req(1'b0, 1'b0, 10'd5, 32'h0, 4'h0);
        @(negedge clk);
        preload(10'd1, 32'h0101A1A1);
        preload(10'd2, 32'h0202B2B2);
        i_req_valid = 1'b1; i_req_addr = 10'd1;
        d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 10'd2;
        t_prev = -1;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            #1;
            check("rr_d_ready", d_req_ready, exp_d);
            check("rr_i_ready", i_req_ready, !exp_d);
            if (t_prev >= 0) check("rr_spacing", cyc - t_prev, 2);
            t_prev = cyc;
            @(posedge clk);
            @(negedge clk);
            check("rr_d_resp", d_resp_valid, exp_d);
            check("rr_i_resp", i_resp_valid, !exp_d);
            check("rr_data", exp_d ? d_resp_data : i_resp_data,
                  exp_d ? 32'h0202B2B2 : 32'h0101A1A1);
            @(posedge clk);
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);

        // 5) zero-strobe write acknowledged without an SRAM write
        preload(10'd9, 32'hCAFEF00D);
        w0 = wr_cnt;
        do_req(1'b1, 1'b1, 10'd9, 32'h12345678, 4'h0);
        check("z_acc_enable", acc_en, 1'b0);
        check("z_acc_wnr", acc_wnr, 1'b1);
        check("z_ack", d_resp_valid, 1'b1);
        @(negedge clk);
        check("z_wr_count", wr_cnt - w0, 0);
        check("z_mem9", mem[9], 32'hCAFEF00D);

        // 6) reset during RMW_RD aborts the pending write
        preload(10'd12, 32'h55667788);
        w0 = wr_cnt;
        do_req(1'b1, 1'b1, 10'd12, 32'h0, 4'b0011);
        check("ab_in_rmw", sram_enable, 1'b1);
        rst = 1'b0;
        #1;
        check("ab_enable_off", sram_enable, 1'b0);
        check("ab_no_resp", d_resp_valid, 1'b0);
        @(negedge clk);
        check("ab_no_resp2", d_resp_valid, 1'b0);
        check("ab_wr_count", wr_cnt - w0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ab_no_resp3", d_resp_valid, 1'b0);
        check("ab_mem12", mem[12], 32'h55667788);
        do_req(1'b1, 1'b0, 10'd12, 32'h0, 4'h0);
        check("ab_readback", d_resp_data, 32'h55667788);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
